// File: rtl/tm1638_responder.sv
// TM1638 device-side emulation: oversampled STB/CLK/DIO, display RAM, key-scan readback.
// Pin-to-action latency 3 clk cycles; no backpressure, master pacing must respect sclk phases >= 4 clk.
module tm1638_responder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stb,
    input  logic        sclk,
    input  logic        dio_in,
    output logic        dio_out,
    output logic        dio_oe,
    input  logic [31:0] keys,
    input  logic [3:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic        disp_on,
    output logic [2:0]  brightness,
    output logic        byte_strobe
);
    typedef enum logic [1:0] {S_IDLE, S_CMD, S_WDATA, S_READ} state_t;

    logic [1:0]  stb_sync_q, sclk_sync_q, dio_sync_q;
    logic        stb_prev_q, sclk_prev_q;
    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [3:0]  ptr_q, ptr_d;
    logic        fixed_q, fixed_d;
    logic        disp_on_q, disp_on_d;
    logic [2:0]  bright_q, bright_d;
    logic [7:0]  rd_shift_q, rd_shift_d;
    logic [23:0] key_buf_q, key_buf_d;
    logic [2:0]  rd_bit_cnt_q, rd_bit_cnt_d;
    logic        dio_out_q, dio_out_d;
    logic        dio_oe_q, dio_oe_d;
    logic        byte_strobe_q, byte_strobe_d;
    logic        ram_we;
    logic [7:0]  ram_q [16];

    logic stb_s, sclk_s, dio_s;
    logic sclk_rise, sclk_fall, stb_rise, stb_fall;
    logic [7:0] rx_byte;

    assign stb_s     = stb_sync_q[1];
    assign sclk_s    = sclk_sync_q[1];
    assign dio_s     = dio_sync_q[1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign stb_rise  = stb_s & ~stb_prev_q;
    assign stb_fall  = ~stb_s & stb_prev_q;
    assign rx_byte   = {dio_s, shift_q[7:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_sync_q  <= 2'b11;
            sclk_sync_q <= 2'b11;
            dio_sync_q  <= 2'b00;
            stb_prev_q  <= 1'b1;
            sclk_prev_q <= 1'b1;
        end else begin
            stb_sync_q  <= {stb_sync_q[0], stb};
            sclk_sync_q <= {sclk_sync_q[0], sclk};
            dio_sync_q  <= {dio_sync_q[0], dio_in};
            stb_prev_q  <= stb_s;
            sclk_prev_q <= sclk_s;
        end
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        ptr_d         = ptr_q;
        fixed_d       = fixed_q;
        disp_on_d     = disp_on_q;
        bright_d      = bright_q;
        rd_shift_d    = rd_shift_q;
        key_buf_d     = key_buf_q;
        rd_bit_cnt_d  = rd_bit_cnt_q;
        byte_strobe_d = 1'b0;
        ram_we        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (stb_fall) begin
                    state_d   = S_CMD;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            S_CMD, S_WDATA: begin
                if (sclk_rise) begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        byte_strobe_d = 1'b1;
                        if (state_q == S_WDATA) begin
                            ram_we = 1'b1;
                            if (!fixed_q) ptr_d = ptr_q + 4'd1;
                        end else begin
                            case (rx_byte[7:6])
                                2'b01: begin
                                    if (rx_byte[1]) begin
                                        state_d      = S_READ;
                                        rd_shift_d   = keys[7:0];
                                        key_buf_d    = keys[31:8];
                                        rd_bit_cnt_d = '0;
                                    end else begin
                                        fixed_d = rx_byte[2];
                                    end
                                end
                                2'b10: begin
                                    disp_on_d = rx_byte[3];
                                    bright_d  = rx_byte[2:0];
                                end
                                2'b11: begin
                                    ptr_d   = rx_byte[3:0];
                                    state_d = S_WDATA;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            end
            S_READ: begin
                if (sclk_fall) begin
                    rd_bit_cnt_d = rd_bit_cnt_q + 3'd1;
                    // Byte boundary: pull the next key byte; the buffer zero-fills behind it.
                    if (rd_bit_cnt_q == 3'd7) begin
                        rd_shift_d = key_buf_q[7:0];
                        key_buf_d  = {8'h00, key_buf_q[23:8]};
                    end else begin
                        rd_shift_d = {1'b0, rd_shift_q[7:1]};
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Frame close comes after byte completion so a coincident last edge still lands.
        if (stb_rise && state_q != S_IDLE) begin
            state_d    = S_IDLE;
            rd_shift_d = '0;
        end
        dio_oe_d  = (state_d == S_READ);
        dio_out_d = (state_d == S_READ) ? rd_shift_d[0] : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            ptr_q         <= '0;
            fixed_q       <= 1'b0;
            disp_on_q     <= 1'b0;
            bright_q      <= '0;
            rd_shift_q    <= '0;
            key_buf_q     <= '0;
            rd_bit_cnt_q  <= '0;
            dio_out_q     <= 1'b0;
            dio_oe_q      <= 1'b0;
            byte_strobe_q <= 1'b0;
            for (int i = 0; i < 16; i++) ram_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            ptr_q         <= ptr_d;
            fixed_q       <= fixed_d;
            disp_on_q     <= disp_on_d;
            bright_q      <= bright_d;
            rd_shift_q    <= rd_shift_d;
            key_buf_q     <= key_buf_d;
            rd_bit_cnt_q  <= rd_bit_cnt_d;
            dio_out_q     <= dio_out_d;
            dio_oe_q      <= dio_oe_d;
            byte_strobe_q <= byte_strobe_d;
            if (ram_we) ram_q[ptr_q] <= rx_byte;
        end
    end

    assign dio_out     = dio_out_q;
    assign dio_oe      = dio_oe_q;
    assign rd_data     = ram_q[rd_addr];
    assign disp_on     = disp_on_q;
    assign brightness  = bright_q;
    assign byte_strobe = byte_strobe_q;
endmodule

// File: tb/tb_tm1638_responder.sv
// Directed bench for tm1638_responder: a bit-banged master drives frames while
// monitors pop queued expectations for probed outputs and for bytes read back on DIO.
module tb_tm1638_responder;
    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb, sclk, dio_in;
    logic        dio_out, dio_oe;
    logic [31:0] keys;
    logic [3:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        disp_on;
    logic [2:0]  brightness;
    logic        byte_strobe;

    tm1638_responder dut (
        .clk(clk), .rst_n(rst_n), .stb(stb), .sclk(sclk), .dio_in(dio_in),
        .dio_out(dio_out), .dio_oe(dio_oe), .keys(keys), .rd_addr(rd_addr),
        .rd_data(rd_data), .disp_on(disp_on), .brightness(brightness),
        .byte_strobe(byte_strobe)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int strobe_cnt = 0;

    int         chk_kind [$];
    logic [7:0] chk_val  [$];
    string      chk_name [$];
    logic [7:0] rd_exp   [$];
    logic       probe_vld = 1'b0;
    int         probe_kind = 0;

    always @(negedge clk) if (byte_strobe === 1'b1) strobe_cnt++;

    // Probe monitor: kind 0 RAM word, 1 disp_on, 2 brightness, 3 dio_oe, 4 strobe count.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (probe_vld) begin
                logic [7:0] act;
                case (chk_kind[0])
                    0: act = rd_data;
                    1: act = {7'b0, disp_on};
                    2: act = {5'b0, brightness};
                    3: act = {7'b0, dio_oe};
                    default: act = strobe_cnt[7:0];
                endcase
                total++;
                if (act !== chk_val[0]) begin
                    bad++;
                    $display("FAIL %s: got %02h expected %02h", chk_name[0], act, chk_val[0]);
                end
                void'(chk_kind.pop_front());
                void'(chk_val.pop_front());
                void'(chk_name.pop_front());
            end
        end
    end

    // Read-back monitor: bit sampled just before each master falling edge.
    initial begin
        logic [7:0] rb;
        int nb;
        nb = 0;
        rb = '0;
        forever begin
            @(negedge sclk);
            if (dio_oe === 1'b1) begin
                rb[nb] = dio_out;
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    total++;
                    if (rd_exp.size() == 0) begin
                        bad++;
                        $display("FAIL key_read_unexpected: got %02h expected none", rb);
                    end else begin
                        if (rb !== rd_exp[0]) begin
                            bad++;
                            $display("FAIL key_read: got %02h expected %02h", rb, rd_exp[0]);
                        end
                        void'(rd_exp.pop_front());
                    end
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic probe(input int kind, input logic [3:0] addr, input logic [7:0] exp, input string nm);
        chk_kind.push_back(kind);
        chk_val.push_back(exp);
        chk_name.push_back(nm);
        rd_addr    = addr;
        probe_kind = kind;
        probe_vld  = 1'b1;
        @(negedge clk);
        probe_vld  = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_frame();
        stb = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic end_frame();
        wait_clk(HALF);
        stb = 1'b1;
        wait_clk(2 * HALF);
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits, input bit close_on_last);
        for (int i = 0; i < nbits; i++) begin
            sclk   = 1'b0;
            dio_in = b[i];
            wait_clk(HALF);
            sclk = 1'b1;
            if (close_on_last && i == nbits - 1) stb = 1'b1;
            wait_clk(HALF);
        end
    endtask

    task automatic read_byte(input logic [7:0] exp);
        rd_exp.push_back(exp);
        for (int i = 0; i < 8; i++) begin
            sclk = 1'b0;
            wait_clk(HALF);
            sclk = 1'b1;
            wait_clk(HALF);
        end
    endtask

    task automatic frame1(input logic [7:0] b0);
        start_frame();
        send_bits(b0, 8, 1'b0);
        end_frame();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; stb = 1'b1; sclk = 1'b1; dio_in = 1'b0;
        keys = '0; rd_addr = '0;
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(5);
        probe(3, 4'd0, 8'h00, "reset_dio_oe");
        probe(1, 4'd0, 8'h00, "reset_disp_on");

        // Auto-increment with wrap 14 -> 15 -> 0.
        frame1(8'h40);
        probe(4, 4'd0, 8'd1, "strobe_after_cmd");
        start_frame();
        send_bits(8'hCE, 8, 1'b0);
        send_bits(8'h11, 8, 1'b0);
        send_bits(8'h22, 8, 1'b0);
        send_bits(8'h33, 8, 1'b0);
        end_frame();
        probe(4, 4'd0, 8'd5, "strobe_count_4_more");
        probe(0, 4'd14, 8'h11, "ram14");
        probe(0, 4'd15, 8'h22, "ram15");
        probe(0, 4'd0,  8'h33, "ram0_wrap");

        // Fixed address: second byte overwrites the same word.
        frame1(8'h44);
        start_frame();
        send_bits(8'hC3, 8, 1'b0);
        send_bits(8'hAA, 8, 1'b0);
        send_bits(8'h55, 8, 1'b0);
        end_frame();
        probe(0, 4'd3, 8'h55, "ram3_fixed");
        probe(0, 4'd4, 8'h00, "ram4_untouched");

        frame1(8'h8D);
        probe(1, 4'd0, 8'h01, "disp_on_8d");
        probe(2, 4'd0, 8'h05, "bright_8d");
        frame1(8'h80);
        probe(1, 4'd0, 8'h00, "disp_on_80");
        probe(2, 4'd0, 8'h00, "bright_80");

        // Key read, including one byte past the end (zero fill).
        keys = 32'h87654321;
        start_frame();
        send_bits(8'h42, 8, 1'b0);
        wait_clk(HALF);
        read_byte(8'h21);
        read_byte(8'h43);
        read_byte(8'h65);
        read_byte(8'h87);
        read_byte(8'h00);
        probe(3, 4'd0, 8'h01, "dio_oe_in_read");
        end_frame();
        probe(3, 4'd0, 8'h00, "dio_oe_after_stb");
        keys = '0;

        // Strobe rising with the final data clock edge still writes the byte.
        start_frame();
        send_bits(8'hC7, 8, 1'b0);
        send_bits(8'h5A, 8, 1'b1);
        wait_clk(2 * HALF);
        probe(0, 4'd7, 8'h5A, "ram7_close_on_last");

        // Aborted frame, then clean decode on the following frames.
        start_frame();
        send_bits(8'hC5, 8, 1'b0);
        send_bits(8'hFF, 5, 1'b0);
        end_frame();
        probe(0, 4'd5, 8'h00, "ram5_abort");
        frame1(8'h8A);
        probe(1, 4'd0, 8'h01, "disp_on_after_abort");
        probe(2, 4'd0, 8'h02, "bright_after_abort");
        start_frame();
        send_bits(8'hC5, 8, 1'b0);
        send_bits(8'h77, 8, 1'b0);
        end_frame();
        probe(0, 4'd5, 8'h77, "ram5_after_abort");

        // Reset asserted mid-frame clears everything.
        start_frame();
        send_bits(8'hC9, 8, 1'b0);
        send_bits(8'hFF, 3, 1'b0);
        rst_n = 1'b0;
        wait_clk(2);
        for (int a = 0; a < 16; a++) probe(0, a[3:0], 8'h00, $sformatf("reset_ram%0d", a));
        probe(3, 4'd0, 8'h00, "reset_mid_dio_oe");
        probe(1, 4'd0, 8'h00, "reset_mid_disp_on");
        probe(2, 4'd0, 8'h00, "reset_mid_bright");
        stb = 1'b1;
        sclk = 1'b1;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(4);

        total++;
        if (chk_kind.size() != 0 || rd_exp.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", chk_kind.size(), rd_exp.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
